// File: rtl/sdram_client_arbiter_if.sv
// sdram_client_arbiter_if: client-side and downstream toggle-handshake signals of the SDRAM client arbiter
interface sdram_client_arbiter_if #(parameter int NCLIENT = 4, parameter int AW = 23, parameter int DW = 16);
  logic [NCLIENT-1:0]         cl_req;
  logic [NCLIENT-1:0]         cl_ack;
  logic [NCLIENT-1:0]         cl_we;
  logic [NCLIENT*AW-1:0]      cl_a;
  logic [NCLIENT*DW-1:0]      cl_d;
  logic [NCLIENT-1:0]         cl_u_n;
  logic [NCLIENT-1:0]         cl_l_n;
  logic [NCLIENT*DW-1:0]      cl_q;
  logic                       mem_req;
  logic                       mem_ack;
  logic                       mem_we;
  logic [AW-1:0]              mem_a;
  logic [DW-1:0]              mem_d;
  logic                       mem_u_n;
  logic                       mem_l_n;
  logic [DW-1:0]              mem_q;
  logic                       busy;
  logic [$clog2(NCLIENT)-1:0] grant_id;
  modport slave (
    input  cl_req, cl_we, cl_a, cl_d, cl_u_n, cl_l_n, mem_ack, mem_q,
    output cl_ack, cl_q, mem_req, mem_we, mem_a, mem_d, mem_u_n, mem_l_n, busy, grant_id
  );
  modport master (
    output cl_req, cl_we, cl_a, cl_d, cl_u_n, cl_l_n, mem_ack, mem_q,
    input  cl_ack, cl_q, mem_req, mem_we, mem_a, mem_d, mem_u_n, mem_l_n, busy, grant_id
  );
endinterface

// File: rtl/sdram_client_arbiter.sv
// sdram_client_arbiter: round-robin share of one toggle-handshake SDRAM port among NCLIENT clients
// Define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module sdram_client_arbiter #(
  parameter int NCLIENT = 4,
  parameter int AW = 23,
  parameter int DW = 16
) (
  input logic clk,
  input logic reset,
  sdram_client_arbiter_if.slave bus
);
  localparam int IW = $clog2(NCLIENT);
  localparam logic [0:0] IDLE = 1'b0, WAIT = 1'b1;
  logic [0:0] state;
  logic [IW-1:0] rr_ptr, win;
  logic [NCLIENT-1:0] pending;
  function automatic logic [IW-1:0] wrap(input int j);
    return IW'(j >= NCLIENT ? j - NCLIENT : j);
  endfunction
  assign pending = bus.cl_req ^ bus.cl_ack;
  assign bus.busy = state == WAIT;
  // Descending scan so the candidate closest to the search start is assigned last and wins.
  always_comb begin
    win = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int k = NCLIENT - 1; k >= 0; k--) if (pending[k]) win = IW'(k);
`else
    for (int k = NCLIENT - 1; k >= 0; k--) if (pending[wrap(int'(rr_ptr) + k)]) win = wrap(int'(rr_ptr) + k);
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      bus.grant_id <= '0;
      bus.cl_ack <= '0;
      bus.cl_q <= '0;
      bus.mem_req <= bus.mem_ack;
      bus.mem_we <= 1'b0;
      bus.mem_a <= '0;
      bus.mem_d <= '0;
      bus.mem_u_n <= 1'b1;
      bus.mem_l_n <= 1'b1;
    end else if (state == IDLE) begin
      if (|pending) begin
        bus.grant_id <= win;
        bus.mem_we <= bus.cl_we[win];
        bus.mem_a <= bus.cl_a[win*AW +: AW];
        bus.mem_d <= bus.cl_d[win*DW +: DW];
        bus.mem_u_n <= bus.cl_u_n[win];
        bus.mem_l_n <= bus.cl_l_n[win];
        bus.mem_req <= ~bus.mem_req;
        state <= WAIT;
      end
    end else if (bus.mem_req == bus.mem_ack) begin
      if (!bus.mem_we) bus.cl_q[bus.grant_id*DW +: DW] <= bus.mem_q;
      bus.cl_ack[bus.grant_id] <= ~bus.cl_ack[bus.grant_id];
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr <= bus.grant_id == IW'(NCLIENT - 1) ? '0 : bus.grant_id + 1'b1;
`endif
      state <= IDLE;
    end
  end
endmodule
